// File: rtl/maj_rx_pkg.sv
// rtl/maj_rx_pkg.sv - shared types, widths and helpers for the oversampling serial front-end
package maj_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam logic IDLE_LEVEL = 1'b1;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with asynchronous active-low reset to RESET_VAL
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/maj_sample_rx.sv
// rtl/maj_sample_rx.sv - start detect and per-slot sample-triple capture ahead of the majority voter
// Optional start-glitch rejection: MAJ_START_GLITCH_REJECT_EN.
module maj_sample_rx
    import maj_rx_pkg::*;
#(
    parameter int OVS       = 16,
    parameter int MID       = 8,
    parameter int DATA_BITS = 8,
    localparam int IDX_W    = cnt_width(DATA_BITS + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             os_tick,
    input  logic             rx_in,
    output logic             smp_a,
    output logic             smp_b,
    output logic             smp_c,
    output logic             smp_valid,
    output logic [IDX_W-1:0] bit_idx,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int              OS_W      = cnt_width(OVS);
    localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVS - 1);
    localparam logic [OS_W-1:0] OS_MID_M1 = OS_W'(MID - 1);
    localparam logic [OS_W-1:0] OS_MID    = OS_W'(MID);
    localparam logic [OS_W-1:0] OS_MID_P1 = OS_W'(MID + 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS);

    logic rx_sync;

    rx_state_e        state_q, state_d;
    logic             rx_prev_q, rx_prev_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic [IDX_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             smp_a_q, smp_a_d;
    logic             smp_b_q, smp_b_d;
    logic             smp_c_q, smp_c_d;
    logic             smp_valid_q, smp_valid_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_end_q, frame_end_d;
    logic             reject;

    sync2 #(
        .RESET_VAL(IDLE_LEVEL)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx_in),
        .q    (rx_sync)
    );

    always_comb begin
        state_d       = state_q;
        rx_prev_d     = rx_prev_q;
        os_cnt_d      = os_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        a_d           = a_q;
        b_d           = b_q;
        smp_a_d       = smp_a_q;
        smp_b_d       = smp_b_q;
        smp_c_d       = smp_c_q;
        smp_valid_d   = 1'b0;
        bit_idx_d     = bit_idx_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        reject        = 1'b0;

        // The edge reference is the line as seen on the previous tick, so
        // a fall is caught on the first tick after it, whatever the tick rate.
        if (os_tick) begin
            rx_prev_d = rx_sync;
        end

        case (state_q)
            ST_IDLE: begin
                if (os_tick && !rx_sync && rx_prev_q) begin
                    state_d   = ST_START;
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                end
            end
            default: begin
                if (os_tick) begin
                    os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);

                    if (os_cnt_q == OS_MID_M1) a_d = rx_sync;
                    if (os_cnt_q == OS_MID)    b_d = rx_sync;

                    if (os_cnt_q == OS_LAST) begin
                        bit_cnt_d = bit_cnt_q + IDX_W'(1);
                        if (state_q == ST_START) begin
                            state_d = ST_DATA;
                        end else if (state_q == ST_DATA && bit_cnt_q == LAST_DATA) begin
                            state_d = ST_STOP;
                        end
                    end

                    // Evaluated after the slot-end branch so that an early
                    // return to IDLE wins when MID+1 is the last oversample.
                    if (os_cnt_q == OS_MID_P1) begin
`ifdef MAJ_START_GLITCH_REJECT_EN
                        reject = (state_q == ST_START) && vote3(a_q, b_q, rx_sync);
`else
                        reject = 1'b0;
`endif
                        if (reject) begin
                            state_d = ST_IDLE;
                        end else begin
                            smp_a_d       = a_q;
                            smp_b_d       = b_q;
                            smp_c_d       = rx_sync;
                            smp_valid_d   = 1'b1;
                            bit_idx_d     = bit_cnt_q;
                            frame_start_d = (state_q == ST_START);
                            frame_end_d   = (state_q == ST_STOP);
                            if (state_q == ST_STOP) begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rx_prev_q     <= IDLE_LEVEL;
            os_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            a_q           <= IDLE_LEVEL;
            b_q           <= IDLE_LEVEL;
            smp_a_q       <= IDLE_LEVEL;
            smp_b_q       <= IDLE_LEVEL;
            smp_c_q       <= IDLE_LEVEL;
            smp_valid_q   <= 1'b0;
            bit_idx_q     <= '0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_prev_q     <= rx_prev_d;
            os_cnt_q      <= os_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            a_q           <= a_d;
            b_q           <= b_d;
            smp_a_q       <= smp_a_d;
            smp_b_q       <= smp_b_d;
            smp_c_q       <= smp_c_d;
            smp_valid_q   <= smp_valid_d;
            bit_idx_q     <= bit_idx_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
        end
    end

    assign smp_a       = smp_a_q;
    assign smp_b       = smp_b_q;
    assign smp_c       = smp_c_q;
    assign smp_valid   = smp_valid_q;
    assign bit_idx     = bit_idx_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_maj_sample_rx.sv
// tb/tb_maj_sample_rx.sv - scoreboard bench for maj_sample_rx driven from a per-tick line waveform
module tb_maj_sample_rx;

    localparam int OVS   = 16;
    localparam int MID   = 8;
    localparam int DB    = 8;
    localparam int IDX_W = $clog2(DB + 2);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             os_tick;
    logic             rx_in;
    logic             smp_a, smp_b, smp_c, smp_valid;
    logic [IDX_W-1:0] bit_idx;
    logic             frame_start, frame_end, busy;

    maj_sample_rx #(.OVS(OVS), .MID(MID), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .os_tick    (os_tick),
        .rx_in      (rx_in),
        .smp_a      (smp_a),
        .smp_b      (smp_b),
        .smp_c      (smp_c),
        .smp_valid  (smp_valid),
        .bit_idx    (bit_idx),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [2:0] abc;
        int         idx;
        bit         fs;
        bit         fe;
    } strobe_t;

    strobe_t exp_q[$];
    strobe_t obs_q[$];
    bit      wave[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    int      tick_cnt = 0;

`ifdef MAJ_START_GLITCH_REJECT_EN
    bit glitch_rej = 1'b1;
`else
    bit glitch_rej = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic add_level(input bit v, input int n);
        for (int i = 0; i < n; i++) wave.push_back(v);
    endtask

    task automatic add_frame(input int data);
        add_level(1'b0, OVS);
        for (int i = 0; i < DB; i++) add_level(data[i], OVS);
        add_level(1'b1, OVS);
    endtask

    // Reference: walk the per-tick line and predict every triple from frame rules.
    function automatic void model(input int cut);
        int t;
        int sz;
        t  = 0;
        sz = wave.size();
        while (t < sz) begin
            bit prv;
            prv = (t == 0) ? 1'b1 : wave[t-1];
            if (wave[t] == 1'b0 && prv) begin
                int base;
                bit rej;
                base = t + 1;
                rej  = 1'b0;
                for (int s = 0; s <= DB + 1; s++) begin
                    int      ts;
                    strobe_t e;
                    ts = base + s * OVS + MID - 1;
                    if (ts + 2 >= sz) return;
                    e.t   = ts + 2;
                    e.abc = {wave[ts], wave[ts+1], wave[ts+2]};
                    e.idx = s;
                    e.fs  = (s == 0);
                    e.fe  = (s == DB + 1);
                    if (glitch_rej && s == 0 &&
                        (int'(wave[ts]) + int'(wave[ts+1]) + int'(wave[ts+2])) >= 2) begin
                        rej = 1'b1;
                        t   = ts + 3;
                        break;
                    end
                    if (e.t < cut) exp_q.push_back(e);
                end
                if (!rej) t = base + (DB + 1) * OVS + MID + 2;
            end else begin
                t++;
            end
        end
    endfunction

    task automatic play(input int n, input int gap_at);
        for (int t = 0; t < n; t++) begin
            rx_in = wave[t];
            if (t == gap_at) begin
                int hits;
                hits = 0;
                repeat (50) begin
                    @(negedge clk);
                    if (smp_valid) hits++;
                end
                chk("tick_gap_quiet", hits, 0);
            end
            repeat ($urandom_range(2, 4)) @(negedge clk);
            os_tick = 1'b1;
            @(negedge clk);
            os_tick = 1'b0;
        end
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk({nm, "_drain"}, exp_q.size(), 0);
        chk({nm, "_busy_idle"}, busy, 0);
    endtask

    task automatic chk_reset(input string nm);
        chk(nm, {smp_a, smp_b, smp_c, smp_valid, frame_start, frame_end, busy, 4'(bit_idx)},
            {7'b1110000, 4'd0});
    endtask

    always @(posedge clk) if (os_tick) tick_cnt <= tick_cnt + 1;

    always @(negedge clk) begin
        if (rst_n && smp_valid) begin
            strobe_t o;
            o.t   = tick_cnt;
            o.abc = {smp_a, smp_b, smp_c};
            o.idx = int'(bit_idx);
            o.fs  = frame_start;
            o.fe  = frame_end;
            obs_q.push_back(o);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {o.abc, 4'(o.idx)}, 32'hffff_ffff);
            end else begin
                strobe_t e;
                e = exp_q.pop_front();
                chk("strobe", {o.abc, 4'(o.idx), o.fs, o.fe}, {e.abc, 4'(e.idx), e.fs, e.fe});
            end
        end
    end

    initial begin
        int         f_a5, f_noise, gap_at, rst_tick;
        logic [9:0] a5_slots;

        rst_n   = 1'b0;
        os_tick = 1'b0;
        rx_in   = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("reset_values");
        rst_n = 1'b1;
        @(negedge clk);

        // Phase 1: one long line covering the directed and random cases.
        add_level(1'b1, 5);
        f_a5 = wave.size();
        add_frame(8'hA5);
        gap_at = f_a5 + 3 * OVS + 5;
        add_level(1'b1, 3);
        f_noise = wave.size();
        add_frame(8'h00);
        wave[f_noise + 1 + 4 * OVS + MID] = 1'b1;
        add_level(1'b1, 4);
        add_level(1'b0, 4);
        add_level(1'b1, 12 * OVS);
        add_frame(int'($urandom_range(0, 255)));
        add_frame(int'($urandom_range(0, 255)));
        add_level(1'b1, 2);
        add_frame(8'h3C);
        add_level(1'b0, 12 * OVS);
        add_level(1'b1, 20);
        for (int i = 0; i < 6; i++) begin
            int fb;
            add_level(1'b1, int'($urandom_range(0, 5)));
            fb = wave.size();
            add_frame(int'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) begin
                int k;
                k = fb + int'($urandom_range(1, (DB + 2) * OVS - 1));
                wave[k] = ~wave[k];
            end
        end
        add_level(1'b1, 12 * OVS);
        model(wave.size());
        play(wave.size(), gap_at);
        drain("phase1");

        // Directed view of the first frame (0xA5): spec triples and 16-tick spacing.
        a5_slots = 10'b1_1010_0101_0;
        chk("a5_count", (obs_q.size() >= 10), 1);
        if (obs_q.size() >= 10) begin
            for (int s = 0; s < 10; s++) begin
                chk($sformatf("a5_slot%0d", s), {obs_q[s].abc, 4'(obs_q[s].idx), obs_q[s].fs, obs_q[s].fe},
                    {{3{a5_slots[s]}}, 4'(s), (s == 0), (s == 9)});
                if (s > 0) chk($sformatf("a5_spacing%0d", s), obs_q[s].t - obs_q[s-1].t, OVS);
            end
        end

        // Phase 2: reset asserted during data bit 4 (slot 5).
        wave.delete();
        add_level(1'b1, 4);
        add_frame(int'($urandom_range(0, 255)));
        rst_tick = 4 + 1 + 5 * OVS + 2;
        model(rst_tick);
        play(rst_tick, -1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("midframe_reset");
        chk("pre_reset_strobes", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk_reset("reset_held");
        rx_in = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        // Phase 3: fresh frame after reset release.
        wave.delete();
        add_level(1'b1, 4);
        add_frame(int'($urandom_range(0, 255)));
        add_level(1'b1, 4);
        model(wave.size());
        chk("post_reset_expected", exp_q.size(), DB + 2);
        play(wave.size(), -1);
        drain("phase3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
